// File: rtl/sram_pkg.sv
// Shared definitions for the 1Mx8 async SRAM bus: default pin widths and the
// chip-responder state encoding.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 20;
  localparam int unsigned SRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE,
    WRITE
  } sram_state_e;

endpackage

// File: rtl/sram_chip_responder_sync_2ff.sv
// Two-flop synchronizer for a bus of WIDTH bits with a configurable reset value.
module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sram_chip_responder.sv
// Device-side responder for the async 1Mx8 SRAM bus: synchronizes the pins,
// serves reads from a block-RAM array and commits writes on ~WE rising.
// Optional SRAM_RESP_STATS_EN adds saturating read/write transaction counters.
module sram_chip_responder
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = SRAM_DATA_WIDTH,
  parameter int unsigned MEM_ADDR_BITS = 12,
  parameter int unsigned READ_LATENCY  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_n_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  inout  wire  [DATA_WIDTH-1:0] io_data,
  input  logic                  i_n_oe,
  input  logic                  i_n_we,
  output logic                  o_err_both,
`ifdef SRAM_RESP_STATS_EN
  output logic [15:0]           o_read_count,
  output logic [15:0]           o_write_count,
`endif
  output logic                  o_busy
);

  localparam logic [3:0] RL = 4'(READ_LATENCY);

  logic                     oe_n_s, we_n_s;
  logic [ADDR_WIDTH-1:0]    addr_s;
  logic [DATA_WIDTH-1:0]    din_s;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_oe (
    .clk_i(i_clk), .rst_ni(i_n_reset), .d_i(i_n_oe), .q_o(oe_n_s));
  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_we (
    .clk_i(i_clk), .rst_ni(i_n_reset), .d_i(i_n_we), .q_o(we_n_s));
  sync_2ff #(.WIDTH(ADDR_WIDTH), .RESET_VAL('0)) u_sync_addr (
    .clk_i(i_clk), .rst_ni(i_n_reset), .d_i(i_addr), .q_o(addr_s));
  sync_2ff #(.WIDTH(DATA_WIDTH), .RESET_VAL('0)) u_sync_data (
    .clk_i(i_clk), .rst_ni(i_n_reset), .d_i(io_data), .q_o(din_s));

  logic [DATA_WIDTH-1:0]    mem [0:(1 << MEM_ADDR_BITS)-1];

  sram_state_e              state_q;
  logic [3:0]               cnt_q;
  logic                     drive_q;
  logic [DATA_WIDTH-1:0]    dout_q;
  logic                     err_q;
  logic [ADDR_WIDTH-1:0]    addr_prev_q;
  logic [MEM_ADDR_BITS-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
`ifdef SRAM_RESP_STATS_EN
  logic [15:0]              rd_cnt_q, wr_cnt_q;
`endif

  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic                     addr_chg;
  logic                     commit;

  assign mem_idx  = addr_s[MEM_ADDR_BITS-1:0];
  assign addr_chg = (addr_s != addr_prev_q);
  assign commit   = (state_q == WRITE) && we_n_s;

  always_ff @(posedge i_clk) begin
    if (commit) mem[wr_addr_q] <= wr_data_q;
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drive_q     <= 1'b0;
      dout_q      <= '0;
      err_q       <= 1'b0;
      addr_prev_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef SRAM_RESP_STATS_EN
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
`endif
    end else begin
      addr_prev_q <= addr_s;
      dout_q      <= mem[mem_idx];
      if (!oe_n_s && !we_n_s) err_q <= 1'b1;

      if (!we_n_s) begin
        state_q   <= WRITE;
        drive_q   <= 1'b0;
        wr_addr_q <= mem_idx;
        wr_data_q <= din_s;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (!oe_n_s) begin
              state_q <= READ_WAIT;
              cnt_q   <= RL;
            end
          end
          READ_WAIT: begin
            // Leaving on the final count places drive RL cycles after entry.
            if (oe_n_s) begin
              state_q <= IDLE;
            end else if (addr_chg) begin
              cnt_q <= RL;
            end else if (cnt_q <= 4'd1) begin
              state_q <= READ_DRIVE;
              cnt_q   <= '0;
              drive_q <= 1'b1;
`ifdef SRAM_RESP_STATS_EN
              if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 16'd1;
`endif
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          READ_DRIVE: begin
            if (oe_n_s) begin
              state_q <= IDLE;
              drive_q <= 1'b0;
            end else if (addr_chg) begin
              state_q <= READ_WAIT;
              cnt_q   <= RL;
              drive_q <= 1'b0;
            end
          end
          WRITE: begin
            state_q <= IDLE;
`ifdef SRAM_RESP_STATS_EN
            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 16'd1;
`endif
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Gating with the synchronized strobes releases the bus without waiting for the FSM edge.
  assign io_data    = (drive_q && !oe_n_s && we_n_s) ? dout_q : 'z;
  assign o_err_both = err_q;
  assign o_busy     = (state_q != IDLE);
`ifdef SRAM_RESP_STATS_EN
  assign o_read_count  = rd_cnt_q;
  assign o_write_count = wr_cnt_q;
`endif

endmodule

// File: doc/sram_chip_responder.md
# sram_chip_responder

Pin-level responder for the asynchronous 1M×8 SRAM bus driven by `sram_1Mx8`. It samples `~OE`, `~WE`, address and data the way the chip would see them. It answers reads from an internal memory array and commits writes on the rising edge of `~WE`. It serves as the device-side partner in benches and on a second FPGA for loopback bring-up of the controller.

## Interface
- `ADDR_WIDTH`, 20, width of the pin address bus.
- `DATA_WIDTH`, 8, width of the data bus.
- `MEM_ADDR_BITS`, 12, depth of the backing array (2^MEM_ADDR_BITS words); address bits above this are ignored.
- `READ_LATENCY`, 2, cycles after a synchronized read request before data is driven (1..15).
- `i_clk`, in, 1, single clock.
- `i_n_reset`, in, 1, asynchronous active-low reset.
- `i_addr`, in, ADDR_WIDTH, address pins from the controller.
- `io_data`, inout, DATA_WIDTH, shared data pins; tristate except while driving read data.
- `i_n_oe`, in, 1, active-low output enable from the controller.
- `i_n_we`, in, 1, active-low write enable from the controller.
- `o_err_both`, out, 1, sticky flag: `~OE` and `~WE` were low together (synchronized).
- `o_busy`, out, 1, high in any state other than IDLE.

## Operation
- All pin inputs (`i_n_oe`, `i_n_we`, `i_addr`, `io_data`) pass through 2-flop synchronizers; all decisions use the synchronized copies.
- Each synchronized cycle also registers the previous address, so an address change can be detected.
- Write has priority over read, and the data driver is off whenever synchronized `~WE` is low.
- **IDLE**
  - `~WE` low → WRITE.
  - else `~OE` low → READ_WAIT, latency counter loaded with READ_LATENCY.
- **READ_WAIT**
  - Counter decrements each cycle; at 0 → READ_DRIVE.
  - Address change restarts the counter.
  - `~OE` high → IDLE.
  - `~WE` low → WRITE.
- **READ_DRIVE**
  - Drives `mem[addr[MEM_ADDR_BITS-1:0]]` on `io_data`.
  - Address change → READ_WAIT: driver released, counter reloaded.
  - `~OE` high → IDLE, driver released the same cycle.
  - `~WE` low → WRITE.
- **WRITE**
  - Address and data are captured every cycle while `~WE` is low.
  - On the synchronized `~WE` rising edge, the last captured word is written to memory, then → IDLE.
  - `~OE` state is ignored during WRITE.
- `o_err_both` sets when synchronized `~OE` and `~WE` are both low. It clears only on reset.
- Addresses alias modulo 2^MEM_ADDR_BITS.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values:
  - `io_data` tristate, drive data 0.
  - `o_err_both` 0, `o_busy` 0.
  - State IDLE, counter 0, synchronizers all 1 for the `~OE`/`~WE` chains and 0 for addr/data.
- Read latency from the pin `~OE` falling edge (address stable) to `io_data` valid: 2 (sync) + 1 (IDLE→READ_WAIT) + READ_LATENCY cycles. This is 5 cycles at default.
- Release: the driver goes off 2 cycles after pin `~OE` rises, or after pin `~WE` falls.
- Write commit: memory is updated 3 cycles after the pin `~WE` rising edge. A read of the same address started afterwards returns the new data.
- The controller must hold address and data stable for ≥3 cycles before `~WE` rises. Otherwise the committed word is whatever was sampled last.
- Reset mid-write aborts the write; memory is unchanged. Reset mid-read releases the bus immediately (asynchronous).

## Configuration
- `SRAM_RESP_STATS_EN`
  - Defined: adds `o_read_count` and `o_write_count` (16-bit each).
    - `o_read_count` increments on each entry to READ_DRIVE.
    - `o_write_count` increments on each write commit.
    - Both saturate at 0xFFFF and reset to 0.
  - Undefined: neither the ports nor the counters exist.

## Structure
- Shared package `sram_pkg`:
  - state enum (IDLE, READ_WAIT, READ_DRIVE, WRITE);
  - default ADDR_WIDTH/DATA_WIDTH constants, shared with `sram_1Mx8`.
- Sub-module `sync_2ff`: parameterized width, async active-low reset with a reset-value parameter. Instantiated once per synchronized bus.
- Memory array inferred as block RAM in the top of this module.

## Test plan
- Reset, then `~OE`/`~WE` held high → `io_data` high-Z, `o_busy`=0, `o_err_both`=0.
- Write 0xA5 to 0x00010 (pulse `~WE` low 4 cycles), then `~OE` low at 0x00010 → 0xA5 driven exactly 5 cycles after `~OE` fall.
- Write 0x3C to 0x01003, then read 0xF1003 → 0x3C, confirming aliasing with MEM_ADDR_BITS=12.
- During READ_DRIVE at 0x00010, change the address to 0x00020 (holds 0x5A) → bus released, then 0x5A driven after READ_LATENCY+1 cycles.
- Drive `~OE` and `~WE` low together for 3 cycles → `o_err_both`=1 and stays 1. The bus is never driven, and the write commits when `~WE` rises.
- Assert `i_n_reset` low in the middle of a `~WE` pulse writing 0x77 to 0x00005 (previously 0x11) → the read after reset returns 0x11. With `SRAM_RESP_STATS_EN`, both counts are 0 after reset.
